// File: rtl/led_fx_scheduler.sv
// led_fx_scheduler: owns the 16-LED bar and shares it between game events.
// Dying (level), hit (pulse) and round-win (pulse) requests are latched,
// arbitrated by fixed priority (win > p1 hit > p2 hit > dying > idle) and
// played back as timed patterns paced by an internal tick prescaler.
//
// Ports:
//   clk         board clock
//   rst_n       asynchronous active-low reset
//   p1_dying    level, player 1 is dying
//   p2_dying    level, player 2 is dying
//   p1_hit      pulse, player 1 took a hit
//   p2_hit      pulse, player 2 took a hit
//   win_req     pulse, round won
//   win_player  sampled with win_req (0 = P1, 1 = P2)
//   led         registered LED drive
//   busy        high while a hit or win pattern is playing
//   state       current FSM state (debug)
module led_fx_scheduler #(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned HIT_TICKS = 4,
  parameter int unsigned WIN_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p1_dying,
  input  logic        p2_dying,
  input  logic        p1_hit,
  input  logic        p2_hit,
  input  logic        win_req,
  input  logic        win_player,
  output logic [15:0] led,
  output logic        busy,
  output logic [1:0]  state
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);
  localparam logic [3:0]    HitLast = 4'(HIT_TICKS - 1);
  localparam logic [3:0]    WinLast = 4'(WIN_TICKS - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDying = 2'd1,
    StHit   = 2'd2,
    StWin   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   led_q, led_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    step_q, step_d;
  logic          phase_q, phase_d;
  logic          pend1_q, pend1_d;
  logic          pend2_q, pend2_d;
  logic          pend_win_q, pend_win_d;
  logic          win_p2_q, win_p2_d;
  logic          hit_p2_q, hit_p2_d;

  logic tick, win_ok, eff_win, eff_win_p2, eff1, eff2, any_dying, arb;

  always_comb begin
    tick      = (presc_q == TickMax);
    any_dying = p1_dying | p2_dying;

    // A win request arriving while a win is already playing is dropped.
    win_ok     = win_req & (state_q != StWin);
    eff_win    = pend_win_q | win_ok;
    eff_win_p2 = win_ok ? win_player : win_p2_q;

    // Hits raised during a win belong to the finished round and are discarded.
    eff1 = (pend1_q | p1_hit) & (state_q != StWin);
    eff2 = (pend2_q | p2_hit) & (state_q != StWin);

    // Arbitration: continuous in idle/dying, win preemption or pattern end
    // in hit, pattern end only in win.
    arb = (state_q == StIdle) || (state_q == StDying)
       || ((state_q == StHit) && (eff_win || (tick && step_q == HitLast)))
       || ((state_q == StWin) && tick && step_q == WinLast);

    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + PW'(1);
    step_d     = step_q;
    phase_d    = phase_q;
    pend1_d    = eff1;
    pend2_d    = eff2;
    pend_win_d = eff_win;
    win_p2_d   = eff_win_p2;
    hit_p2_d   = hit_p2_q;

    if (tick && (state_q == StHit || state_q == StWin)) step_d = step_q + 4'd1;
    if (tick && state_q == StDying) phase_d = ~phase_q;

    if (arb) begin
      if (eff_win) begin
        state_d    = StWin;
        presc_d    = '0;
        step_d     = '0;
        pend_win_d = 1'b0;
        pend1_d    = 1'b0;
        pend2_d    = 1'b0;
      end else if (eff1 || eff2) begin
        // Entry (or back-to-back re-entry) restarts the pattern.
        state_d  = StHit;
        presc_d  = '0;
        step_d   = '0;
        hit_p2_d = ~eff1;
        pend1_d  = 1'b0;
        pend2_d  = eff1 & eff2;
      end else if (any_dying) begin
        state_d = StDying;
        if (state_q != StDying) begin
          presc_d = '0;
          phase_d = 1'b0;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    led_d = '0;
    unique case (state_q)
      StIdle:  led_d = '0;
      StDying: begin
        led_d[15] = phase_q & p1_dying;
        led_d[0]  = phase_q & p2_dying;
      end
      StHit:   led_d = step_q[0] ? 16'h0000 : (hit_p2_q ? 16'h00FF : 16'hFF00);
      StWin:   led_d = win_p2_q ? (16'h0001 << step_q) : (16'h8000 >> step_q);
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      led_q      <= '0;
      presc_q    <= '0;
      step_q     <= '0;
      phase_q    <= 1'b0;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      pend_win_q <= 1'b0;
      win_p2_q   <= 1'b0;
      hit_p2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      presc_q    <= presc_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      pend_win_q <= pend_win_d;
      win_p2_q   <= win_p2_d;
      hit_p2_q   <= hit_p2_d;
    end
  end

  assign led   = led_q;
  assign busy  = (state_q == StHit) || (state_q == StWin);
  assign state = state_q;

endmodule

// File: tb/tb_led_fx_scheduler.sv
module tb_led_fx_scheduler;
  localparam int TD = 4;
  localparam int HT = 4;
  localparam int WT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p1_dying = 1'b0, p2_dying = 1'b0;
  logic        p1_hit = 1'b0, p2_hit = 1'b0;
  logic        win_req = 1'b0, win_player = 1'b0;
  logic [15:0] led;
  logic        busy;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  led_fx_scheduler #(.TICK_DIV(TD), .HIT_TICKS(HT), .WIN_TICKS(WT)) dut (
    .clk(clk), .rst_n(rst_n), .p1_dying(p1_dying), .p2_dying(p2_dying),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .win_req(win_req), .win_player(win_player),
    .led(led), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: an activity plus the number of cycles spent in it.
  // Pattern step and blink phase follow from elapsed time: step = k / TD.
  int          m_mode;  // 0 idle, 1 dying, 2 hit, 3 win
  int          m_k;
  bit          m_hp2, m_wp2, m_pw, m_p1, m_p2;
  logic [15:0] m_led;

  function automatic void model_reset();
    m_mode = 0; m_k = 0; m_hp2 = 0; m_wp2 = 0;
    m_pw = 0; m_p1 = 0; m_p2 = 0; m_led = '0;
  endfunction

  function automatic void model_advance();
    int s;
    logic [15:0] nl;
    bit ew, wp, e1, e2, pat_end, decide;
    s = m_k / TD;
    nl = '0;
    case (m_mode)
      1: if ((s % 2) == 1) begin nl[15] = p1_dying; nl[0] = p2_dying; end
      2: nl = ((s % 2) == 0) ? (m_hp2 ? 16'h00FF : 16'hFF00) : 16'h0000;
      3: nl = m_wp2 ? (16'h0001 << s) : (16'h8000 >> s);
      default: nl = '0;
    endcase
    ew = m_pw || (win_req && m_mode != 3);
    wp = (win_req && m_mode != 3) ? win_player : m_wp2;
    e1 = (m_p1 || p1_hit) && m_mode != 3;
    e2 = (m_p2 || p2_hit) && m_mode != 3;
    pat_end = (m_mode == 2 && m_k == HT * TD - 1) || (m_mode == 3 && m_k == WT * TD - 1);
    decide = (m_mode <= 1) || (m_mode == 2 && ew) || pat_end;
    m_pw = ew; m_p1 = e1; m_p2 = e2; m_wp2 = wp;
    m_k = m_k + 1;
    if (decide) begin
      if (ew) begin
        m_mode = 3; m_k = 0; m_pw = 0; m_p1 = 0; m_p2 = 0;
      end else if (e1 || e2) begin
        m_mode = 2; m_k = 0; m_hp2 = !e1; m_p1 = 0; m_p2 = e1 && e2;
      end else if (p1_dying || p2_dying) begin
        if (m_mode != 1) begin m_mode = 1; m_k = 0; end
      end else begin
        m_mode = 0;
      end
    end
    m_led = nl;
  endfunction

  // Advance one clock: model sees the same inputs the DUT samples.
  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    p1_hit = 0; p2_hit = 0; win_req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({state, busy, led} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got state=%0d busy=%0b led=%h, want 0/0/0000", state, busy, led);
    end
    rst_n = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      vectors++;
      if ({state, busy, led} !== 19'd0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: got state=%0d busy=%0b led=%h, want idle", i, state,
                 busy, led);
      end
    end
  endtask

  task automatic test_dying();
    p1_dying = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      vectors++;
      if ({state, busy, led} !== {2'(m_mode), m_mode >= 2, m_led}) begin
        miscompares++;
        $display("FAIL dying cyc%0d: got %0d/%0b/%h, want %0d/%0b/%h", i, state, busy, led,
                 m_mode, m_mode >= 2, m_led);
      end
    end
    p1_dying = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({state, busy, led} !== {2'(m_mode), m_mode >= 2, m_led}) begin
        miscompares++;
        $display("FAIL dying_exit cyc%0d: got %0d/%0b/%h, want %0d/%0b/%h", i, state, busy, led,
                 m_mode, m_mode >= 2, m_led);
      end
    end
  endtask

  task automatic test_hit_over_dying();
    p2_dying = 1;
    for (int i = 0; i < 42; i++) begin
      if (i == 9) p1_hit = 1;
      step();
      vectors++;
      if ({state, busy, led} !== {2'(m_mode), m_mode >= 2, m_led}) begin
        miscompares++;
        $display("FAIL hit_over_dying cyc%0d: got %0d/%0b/%h, want %0d/%0b/%h", i, state, busy,
                 led, m_mode, m_mode >= 2, m_led);
      end
    end
    p2_dying = 0;
    repeat (3) step();
  endtask

  task automatic test_dual_hit();
    p1_hit = 1; p2_hit = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if ({state, busy, led} !== {2'(m_mode), m_mode >= 2, m_led}) begin
        miscompares++;
        $display("FAIL dual_hit cyc%0d: got %0d/%0b/%h, want %0d/%0b/%h", i, state, busy, led,
                 m_mode, m_mode >= 2, m_led);
      end
    end
  endtask

  task automatic test_win_preempts_hit();
    p1_hit = 1;
    step();
    repeat (5) step();
    win_req = 1; win_player = 1;
    for (int i = 0; i < 72; i++) begin
      if (i == 20) p2_hit = 1;
      step();
      vectors++;
      if ({state, busy, led} !== {2'(m_mode), m_mode >= 2, m_led}) begin
        miscompares++;
        $display("FAIL win_preempt cyc%0d: got %0d/%0b/%h, want %0d/%0b/%h", i, state, busy,
                 led, m_mode, m_mode >= 2, m_led);
      end
    end
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("FAIL win_end_idle: got state=%0d, want 0", state);
    end
  endtask

  task automatic test_reset_mid_win();
    win_req = 1; win_player = 0; p1_hit = 0;
    step();
    p1_hit = 1;
    repeat (4 * 7 + 2) step();
    #2 rst_n = 0;
    #1;
    model_reset();
    vectors++;
    if ({state, busy, led} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_mid_win: got state=%0d busy=%0b led=%h, want 0/0/0000", state, busy,
               led);
    end
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if ({state, busy, led} !== 19'd0) begin
        miscompares++;
        $display("FAIL after_reset cyc%0d: got %0d/%0b/%h, want idle", i, state, busy, led);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) p1_dying = ~p1_dying;
      if ($urandom_range(0, 59) == 0) p2_dying = ~p2_dying;
      p1_hit = ($urandom_range(0, 29) == 0);
      p2_hit = ($urandom_range(0, 29) == 0);
      win_req = ($urandom_range(0, 79) == 0);
      win_player = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if ({state, busy, led} !== {2'(m_mode), m_mode >= 2, m_led}) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %0d/%0b/%h, want %0d/%0b/%h", i, state, busy, led,
                 m_mode, m_mode >= 2, m_led);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dying();
    test_hit_over_dying();
    test_dual_hit();
    test_win_preempts_hit();
    test_reset_mid_win();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_fx_scheduler.md
Name: led_fx_scheduler

Overview:
- Owns the 16-LED bar and shares it between game-event requesters: player dying, player hit and round win.
- Arbitrates by fixed priority and sequences a timed pattern for each event.
- Runs on the board clock with an internal tick prescaler (10 Hz by default).
- Drives led[15:0] directly, replacing the per-player dying blink logic on the top level.

Parameters:
- TICK_DIV, 10_000_000, clk cycles per pattern tick (100 MHz -> 10 Hz); minimum 2.
- HIT_TICKS, 4, number of ticks in a hit pattern; range 1..16.
- WIN_TICKS, 16, number of ticks in a win chase; range 1..16.

Ports:
- clk  input  1  board clock.
- rst_n  input  1  asynchronous, active-low reset.
- p1_dying  input  1  level; player 1 is in the dying state.
- p2_dying  input  1  level; player 2 is in the dying state.
- p1_hit  input  1  single-cycle pulse; player 1 took a hit.
- p2_hit  input  1  single-cycle pulse; player 2 took a hit.
- win_req  input  1  single-cycle pulse; round won.
- win_player  input  1  sampled with win_req; 0 = P1, 1 = P2.
- led  output  16  registered LED drive.
- busy  output  1  high while in S_HIT or S_WIN.
- state  output  2  current FSM state, for debug.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. Reset clears all registers: state = S_IDLE, led = 0, busy = 0, pending flags = 0, prescaler = 0, step = 0, phase = 0.
- Prescaler: counts 0..TICK_DIV-1. tick is high for one cycle when the count equals TICK_DIV-1. The prescaler clears to 0 on every entry into S_HIT, S_WIN or S_DYING, so step 0 lasts exactly TICK_DIV cycles.
- Pending latches:
  - p1_hit / p2_hit set pend1 / pend2. These are sticky until served; a repeat pulse while pending merges into the existing flag.
  - win_req sets pend_win and captures win_player, except while in S_WIN, where it is dropped.
- States and encoding: S_IDLE = 0, S_DYING = 1, S_HIT = 2, S_WIN = 3.
- Arbitration: evaluated in S_IDLE and S_DYING every cycle, and in S_HIT / S_WIN only at pattern end.
  - Priority order: pend_win > pend1 > pend2 > (p1_dying | p2_dying) > idle.
  - Preemption: a pend_win preempts S_HIT or S_DYING on the next cycle.
  - A hit preempts S_DYING; a hit never preempts S_HIT.
- Entering S_WIN: clears pend_win, pend1 and pend2. Hits from the finished round are discarded.
- Entering S_HIT: step = 0. The player is latched as hit_p2 = ~pend1, and the served pending flag is cleared.
- S_HIT:
  - led = step even ? (P1 ? 16'hFF00 : 16'h00FF) : 16'h0000.
  - step increments on tick.
  - On a tick with step = HIT_TICKS-1, the FSM re-arbitrates.
- S_WIN:
  - led = P1 ? (16'h8000 >> step) : (16'h0001 << step).
  - step increments on tick.
  - On a tick with step = WIN_TICKS-1, the FSM re-arbitrates.
- S_DYING:
  - phase is cleared on entry and toggles on each tick.
  - led[15] = phase & p1_dying; led[0] = phase & p2_dying; all other LEDs are 0.
  - Exit to S_IDLE occurs the cycle after both dying inputs are low.
- S_IDLE: led = 0.
- Latency: an event pulse or level at cycle N gives the new state at N+1. led shows that state's step-0 value at N+2, since led is registered from state/step/phase.
- Simultaneous events:
  - win_req with a hit pulse in the same cycle: WIN is taken and the hit is discarded.
  - p1_hit and p2_hit together: P1 is served, then P2, back-to-back with no idle cycle.
- Mid-operation reset: an asynchronous reset takes immediate effect; led = 0 with no glitch pattern.

Test Plan (TICK_DIV = 4, HIT_TICKS = 4, WIN_TICKS = 16):
- Reset and idle: rst_n low, then release with all inputs 0 -> led = 0, busy = 0, state = 0 for 100 cycles.
- Dying blink: hold p1_dying = 1 -> state = 1 within 1 cycle; led[15] toggles every 4 cycles, starting 0 and first going to 1 about 4 cycles after entry; led[14:0] = 0. Deassert p1_dying -> led = 0 and state = 0 within 2 cycles.
- Hit over dying: p2_dying held, then a p1_hit pulse -> led = FF00 / 0000 / FF00 / 0000, each value for 4 cycles (16 cycles total), busy = 1; then a return to S_DYING with led[0] blinking.
- Dual hit: p1_hit and p2_hit in the same cycle -> 16 cycles of the FF00 pattern, then 16 cycles of the 00FF pattern, then led = 0.
- Win preempts hit: in S_HIT at step 1, win_req with win_player = 1 -> next cycle state = 3; led walks 0001, 0002, ..., 8000 at 4 cycles per step. A p2_hit issued during the win is ignored; afterwards state = 0.
- Reset mid-win: assert rst_n at step 7 -> led = 0 and state = 0 immediately; no pending flags survive.
